// File: rtl/sched_pkg.sv
// Shared state encoding and width helpers for the output-port scheduler.
package sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int width_sel(input int ports);
    return width_of(ports);
  endfunction

  function automatic int width_priority(input int levels);
    return width_of(levels);
  endfunction

  function automatic int width_beat(input int beats_max);
    return $clog2(beats_max) + 1;
  endfunction

  function automatic int width_idle(input int timeout);
    return width_of(timeout);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: grants the first requester at or after ptr, wrapping upward.
module rr_arbiter
  import sched_pkg::*;
#(
  parameter  int N  = 8,
  localparam int WS = width_sel(N)
) (
  input  logic [N-1:0]  req,
  input  logic [WS-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int w_best_dist;
  int w_dist;

  // Pick the requester with the smallest wrap-around distance from the pointer.
  always_comb begin
    gnt         = '0;
    w_best_dist = N;
    w_dist      = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + N - int'(ptr));
      if (req[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        gnt         = '0;
        gnt[j]      = 1'b1;
      end else begin
        gnt         = gnt;
      end
    end
  end

endmodule

// File: rtl/out_port_scheduler.sv
// Output-port scheduler: arbitrates input ports (strict priority or plain round-robin)
// and holds the grant for one packet, releasing on eop, overlength or idle timeout.
module out_port_scheduler
  import sched_pkg::*;
#(
  parameter  int PORT_NUB_TOTAL  = 8,
  parameter  int PRIORITY        = 4,
  parameter  int DATA_LENGTH_MAX = 128,
  parameter  int TIMEOUT         = 256,
  localparam int WIDTH_SEL       = width_sel(PORT_NUB_TOTAL),
  localparam int WIDTH_PRIORITY  = width_priority(PRIORITY)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [PORT_NUB_TOTAL-1:0]                req,
  input  logic [PORT_NUB_TOTAL*WIDTH_PRIORITY-1:0] req_pri,
  input  logic                                     qos_controll,
  input  logic                                     ready,
  input  logic                                     pkt_vld,
  input  logic                                     pkt_eop,
  output logic [PORT_NUB_TOTAL-1:0]                grant,
  output logic [WIDTH_SEL-1:0]                     sel,
  output logic                                     busy,
  output logic                                     error
);

  localparam int WIDTH_BEAT = width_beat(DATA_LENGTH_MAX);
  localparam int WIDTH_IDLE = width_idle(TIMEOUT);
  localparam logic [WIDTH_BEAT-1:0] BEAT_MAX = WIDTH_BEAT'(DATA_LENGTH_MAX);
  localparam logic [WIDTH_IDLE-1:0] IDLE_MAX = WIDTH_IDLE'(TIMEOUT - 1);
  localparam logic [WIDTH_SEL-1:0]  SEL_LAST = WIDTH_SEL'(PORT_NUB_TOTAL - 1);

  sched_state_e                r_state;
  sched_state_e                w_state_nxt;
  logic [PORT_NUB_TOTAL-1:0]   r_grant;
  logic [WIDTH_SEL-1:0]        r_sel;
  logic                        r_error;
  logic [WIDTH_BEAT-1:0]       r_beat_cnt;
  logic [WIDTH_IDLE-1:0]       r_idle_cnt;
  logic [WIDTH_SEL-1:0]        r_ptr [PRIORITY];

  logic [WIDTH_PRIORITY-1:0]   w_top_pri;
  logic [WIDTH_PRIORITY-1:0]   w_lvl;
  logic [PORT_NUB_TOTAL-1:0]   w_req_mask;
  logic [PORT_NUB_TOTAL-1:0]   w_win;
  logic [WIDTH_SEL-1:0]        w_ptr_sel;
  logic [WIDTH_SEL-1:0]        w_win_idx;
  logic [WIDTH_SEL-1:0]        w_ptr_upd;
  logic                        w_arb;
  logic                        w_release;
  logic                        w_fault;

  // Find the highest requesting level and mask the contenders down to it in QoS mode.
  always_comb begin
    w_top_pri  = '0;
    w_req_mask = '0;
    for (int i = 0; i < PORT_NUB_TOTAL; i++) begin
      w_top_pri = (req[i] && (req_pri[i*WIDTH_PRIORITY +: WIDTH_PRIORITY] > w_top_pri))
                ? req_pri[i*WIDTH_PRIORITY +: WIDTH_PRIORITY] : w_top_pri;
    end
    for (int i = 0; i < PORT_NUB_TOTAL; i++) begin
      w_req_mask[i] = qos_controll
                    ? (req[i] && (req_pri[i*WIDTH_PRIORITY +: WIDTH_PRIORITY] == w_top_pri))
                    : req[i];
    end
    w_lvl     = qos_controll ? w_top_pri : '0;
    w_ptr_sel = r_ptr[w_lvl];
  end

  rr_arbiter #(.N(PORT_NUB_TOTAL)) u_rr_arbiter (
    .req (w_req_mask),
    .ptr (w_ptr_sel),
    .gnt (w_win)
  );

  // Encode the one-hot winner and derive the pointer that follows it.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < PORT_NUB_TOTAL; i++) begin
      w_win_idx = w_win[i] ? WIDTH_SEL'(i) : w_win_idx;
    end
    w_ptr_upd = (w_win_idx == SEL_LAST) ? '0 : (w_win_idx + WIDTH_SEL'(1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ((|req) && ready) ? ST_GRANT : ST_IDLE;
      ST_GRANT: w_state_nxt = w_release ? ST_IDLE : ST_GRANT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state decode of arbitration, release causes and protocol faults.
  always_comb begin
    w_arb     = 1'b0;
    w_release = 1'b0;
    w_fault   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_arb   = (|req) && ready;
        w_fault = pkt_vld;
      end
      ST_GRANT: begin
        w_fault   = (pkt_vld && !pkt_eop && (r_beat_cnt == BEAT_MAX))
                  || (!pkt_vld && (r_idle_cnt == IDLE_MAX));
        w_release = (pkt_vld && pkt_eop) || w_fault;
      end
      default: begin
        w_arb     = 1'b0;
        w_release = 1'b0;
        w_fault   = 1'b0;
      end
    endcase
  end

  // Grant, pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant    <= '0;
      r_sel      <= '0;
      r_error    <= 1'b0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
      for (int p = 0; p < PRIORITY; p++) begin
        r_ptr[p] <= '0;
      end
    end else begin
      r_error <= w_fault;
      case (r_state)
        ST_IDLE: begin
          if (w_arb) begin
            r_grant      <= w_win;
            r_sel        <= w_win_idx;
            r_ptr[w_lvl] <= w_ptr_upd;
            r_beat_cnt   <= '0;
            r_idle_cnt   <= '0;
          end else begin
            r_grant      <= '0;
          end
        end
        ST_GRANT: begin
          r_grant    <= w_release ? '0 : r_grant;
          r_beat_cnt <= pkt_vld ? (r_beat_cnt + WIDTH_BEAT'(1)) : r_beat_cnt;
          r_idle_cnt <= pkt_vld ? '0 : (r_idle_cnt + WIDTH_IDLE'(1));
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = (r_state == ST_GRANT);
  assign error = r_error;

endmodule

// File: tb/tb_out_port_scheduler.sv
// Directed bench for out_port_scheduler with a cycle-level reference model and
// literal checks on the key scenarios.
module tb_out_port_scheduler;

  localparam int N    = 8;
  localparam int WP   = 2;
  localparam int DML  = 128;
  localparam int TMO  = 256;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*WP-1:0] req_pri;
  logic          qos_controll;
  logic          ready;
  logic          pkt_vld;
  logic          pkt_eop;
  logic [N-1:0]  grant;
  logic [2:0]    sel;
  logic          busy;
  logic          error;

  int n_checks = 0;
  int n_errors = 0;

  out_port_scheduler #(
    .PORT_NUB_TOTAL (N),
    .PRIORITY       (4),
    .DATA_LENGTH_MAX(DML),
    .TIMEOUT        (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_pri      (req_pri),
    .qos_controll (qos_controll),
    .ready        (ready),
    .pkt_vld      (pkt_vld),
    .pkt_eop      (pkt_eop),
    .grant        (grant),
    .sel          (sel),
    .busy         (busy),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-level scheduler state in plain integers.
  int m_ptr [4];
  int m_port, m_beats, m_idle, m_lvl, m_found, m_p;
  bit m_busy, m_err;

  function automatic int pri_of(input int k);
    return int'(req_pri[k*WP +: WP]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) m_ptr[k] = 0;
      m_port = 0; m_beats = 0; m_idle = 0; m_busy = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (!m_busy) begin
        if (pkt_vld) m_err = 1;
        if (req != '0 && ready) begin
          m_lvl = 0;
          if (qos_controll)
            for (int k = 0; k < N; k++)
              if (req[k] && pri_of(k) > m_lvl) m_lvl = pri_of(k);
          m_found = -1;
          for (int k = 0; k < N; k++) begin
            m_p = (m_ptr[m_lvl] + k) % N;
            if (m_found < 0 && req[m_p] && (!qos_controll || pri_of(m_p) == m_lvl))
              m_found = m_p;
          end
          m_port = m_found;
          m_ptr[m_lvl] = (m_found + 1) % N;
          m_busy = 1; m_beats = 0; m_idle = 0;
        end
      end else if (pkt_vld) begin
        if (pkt_eop) m_busy = 0;
        else if (m_beats == DML) begin m_busy = 0; m_err = 1; end
        m_beats++;
        m_idle = 0;
      end else begin
        if (m_idle == TMO - 1) begin m_busy = 0; m_err = 1; end
        m_idle++;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    check("grant", 32'(grant), m_busy ? (32'd1 << m_port) : 32'd0);
    check("sel",   32'(sel),   32'(m_port));
    check("busy",  32'(busy),  32'(m_busy));
    check("error", 32'(error), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int first_err, err_cnt, busy_fall;
  bit seen;

  initial begin
    rst = 1'b1; req = '0; req_pri = '0; qos_controll = 1'b0;
    ready = 1'b1; pkt_vld = 1'b0; pkt_eop = 1'b0;
    tick(); tick(); tick();
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_sel",   32'(sel),   32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    rst = 1'b0;
    tick();

    // Pure round-robin, 2-beat packets back to back.
    req = 8'hFF;
    for (int p = 0; p < 9; p++) begin
      tick();
      check("rr_grant", 32'(grant), 32'd1 << (p % 8));
      check("rr_sel",   32'(sel),   32'(p % 8));
      pkt_vld = 1'b1; pkt_eop = 1'b0;
      tick();
      pkt_eop = 1'b1;
      if (p == 8) req = 8'h00;
      tick();
      pkt_vld = 1'b0; pkt_eop = 1'b0;
    end
    check("rr_idle_busy", 32'(busy), 32'd0);

    // Strict priority: port 4 (level 3) starves port 0 (level 1).
    qos_controll = 1'b1;
    req_pri = 16'h0301;
    req = 8'h11;
    for (int p = 0; p < 3; p++) begin
      tick();
      check("qos_grant", 32'(grant), 32'h10);
      pkt_vld = 1'b1; pkt_eop = 1'b1;
      if (p == 2) req = 8'h00;
      tick();
      pkt_vld = 1'b0; pkt_eop = 1'b0;
    end
    qos_controll = 1'b0;
    req_pri = '0;

    // 20-beat packet with ready dropped and a gap mid-packet.
    req = 8'h04;
    tick();
    check("long_grant", 32'(grant), 32'h04);
    req = 8'h00; ready = 1'b0;
    for (int b = 1; b <= 20; b++) begin
      if (b == 11) begin
        pkt_vld = 1'b0; tick();
        check("long_gap_hold", 32'(grant), 32'h04);
      end
      pkt_vld = 1'b1; pkt_eop = (b == 20);
      tick();
      if (b < 20) check("long_hold", 32'(grant), 32'h04);
    end
    pkt_vld = 1'b0; pkt_eop = 1'b0;
    check("long_end_busy",  32'(busy),  32'd0);
    check("long_end_error", 32'(error), 32'd0);
    ready = 1'b1;
    tick();

    // Idle timeout: no beats after the grant.
    req = 8'h08;
    tick();
    check("tmo_grant", 32'(grant), 32'h08);
    req = 8'h00;
    first_err = 0; err_cnt = 0; busy_fall = 0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (error) begin
        err_cnt++;
        if (first_err == 0) first_err = c;
      end
      if (!busy && busy_fall == 0) busy_fall = c;
    end
    check("tmo_err_cycle",  32'(first_err), 32'd256);
    check("tmo_err_count",  32'(err_cnt),   32'd1);
    check("tmo_busy_cycle", 32'(busy_fall), 32'd256);

    // Overlength packet: 129 beats without eop.
    req = 8'h01;
    tick();
    check("ovl_grant", 32'(grant), 32'h01);
    req = 8'h00;
    seen = 1'b0; first_err = 0;
    pkt_vld = 1'b1; pkt_eop = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (error && !seen) begin seen = 1'b1; first_err = k; end
      pkt_vld = !seen;
    end
    pkt_vld = 1'b0;
    check("ovl_err_beat", 32'(first_err), 32'd129);
    check("ovl_busy",     32'(busy),      32'd0);

    // Beat while idle is a fault.
    pkt_vld = 1'b1;
    tick();
    pkt_vld = 1'b0;
    check("idle_vld_error", 32'(error), 32'd1);
    tick();
    check("idle_vld_clear", 32'(error), 32'd0);

    // Reset in the middle of a packet.
    req = 8'hFF;
    tick();
    req = 8'h00;
    pkt_vld = 1'b1;
    for (int b = 0; b < 4; b++) tick();
    #1 rst = 1'b1;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_error", 32'(error), 32'd0);
    #1 rst = 1'b0;
    pkt_vld = 1'b0;
    req = 8'hFF;
    tick();
    check("post_rst_grant", 32'(grant), 32'h01);
    req = 8'h00;
    pkt_vld = 1'b1; pkt_eop = 1'b1;
    tick();
    pkt_vld = 1'b0; pkt_eop = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/out_port_scheduler.md
OUT_PORT_SCHEDULER -- requirements
Module: out_port_scheduler

Interface
REQ-001 Parameter PORT_NUB_TOTAL, default 8: number of input ports contending for this output.
REQ-002 Parameter PRIORITY, default 4: priority levels (WIDTH_PRIORITY = clog2(PRIORITY)); larger value is higher priority.
REQ-003 Parameter DATA_LENGTH_MAX, default 128: maximum beats per packet.
REQ-004 Parameter TIMEOUT, default 256: maximum idle cycles tolerated inside a granted packet.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req  in  PORT_NUB_TOTAL  bit i: input i has a packet at its head destined here.
REQ-008 req_pri  in  PORT_NUB_TOTAL*WIDTH_PRIORITY  head-packet priority; slice i at [i*WP +: WP].
REQ-009 qos_controll  in  1  1: strict priority + per-level round-robin; 0: pure round-robin, priority ignored.
REQ-010 ready  in  1  downstream can start a new packet.
REQ-011 pkt_vld  in  1  beat transferred from the granted input this cycle.
REQ-012 pkt_eop  in  1  last beat; meaningful only with pkt_vld.
REQ-013 grant  out  PORT_NUB_TOTAL  registered one-hot grant, zero when idle.
REQ-014 sel  out  clog2(PORT_NUB_TOTAL)  binary index of grant; holds the last winner when idle.
REQ-015 busy  out  1  high while in GRANT.
REQ-016 error  out  1  one-cycle pulse on a protocol fault.

Function
REQ-017 The FSM SHALL have two states: IDLE and GRANT.
REQ-018 IDLE->GRANT when |req && ready; grant/sel/busy become valid on the next clock edge (1-cycle latency).
REQ-019 With qos_controll=1, only requesters at the highest requesting priority level SHALL compete; the winner is the first requester at or after that level's pointer, scanning upward with wrap-around.
REQ-020 With qos_controll=0, all requesters SHALL compete using the level-0 pointer.
REQ-021 On grant, the pointer used SHALL be set to winner+1 modulo PORT_NUB_TOTAL; other pointers are unchanged.
REQ-022 In GRANT, grant SHALL hold regardless of ready or req changes until release.
REQ-023 A beat counter (WIDTH clog2(DATA_LENGTH_MAX)+1) SHALL increment on each pkt_vld and clear on entering GRANT.
REQ-024 An idle counter SHALL increment on each GRANT cycle without pkt_vld and clear on pkt_vld.
REQ-025 Normal release: pkt_vld && pkt_eop -> IDLE next edge with no error; this forces at least one IDLE bubble between packets.
REQ-026 Overlength release: pkt_vld && !pkt_eop when the beat count already equals DATA_LENGTH_MAX -> IDLE next edge with error pulse.
REQ-027 Timeout release: idle counter reaches TIMEOUT-1 without pkt_vld -> IDLE next edge with error pulse.
REQ-028 pkt_vld while IDLE SHALL pulse error and be otherwise ignored.
REQ-029 A single-beat packet (pkt_vld && pkt_eop on the first GRANT cycle) SHALL be legal.
REQ-030 A change in req or req_pri during GRANT SHALL not affect the current grant and SHALL be sampled at the next IDLE arbitration.

Reset
REQ-031 Asserting rst SHALL immediately force: state IDLE, grant 0, sel 0, busy 0, error 0, all pointers 0, all counters 0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet without an error pulse.

Structure
REQ-033 Package sched_pkg SHALL hold the state encoding and width helper functions (WIDTH_SEL, WIDTH_PRIORITY, counter widths).
REQ-034 A sub-module rr_arbiter (N-way one-hot round-robin from request vector and pointer) SHALL be instantiated once, fed by the masked request vector and the selected pointer.

Verification
REQ-035 N=8, qos=0, req=0xFF, ready=1, 2-beat packets back to back -> grants 0,1,...,7,0 in order, each one cycle after IDLE.
REQ-036 qos=1, req=0x11, pri[0]=1, pri[4]=3 -> grant=0x10; after its eop with req still 0x11 -> port 4 again; port 0 is starved while port 4 requests.
REQ-037 Granted packet of 20 beats with ready dropped mid-packet -> grant holds for all 20 beats, then busy falls, error stays 0.
REQ-038 Grant followed by no pkt_vld for 256 cycles -> release and error pulse exactly once at cycle 256.
REQ-039 129 beats with no eop -> release and error pulse on the 129th beat; pkt_vld in IDLE -> error pulse.
REQ-040 rst pulsed at beat 5 of a packet -> grant=0, busy=0, error=0 immediately; next arbitration starts from port 0.
